// File: rtl/egr_pkt_fifo_pkg.sv
// Egress packet FIFO package: sizing constants and producer-side control decode.
`ifndef EGR_BRIDGE_DEFS_SV
`include "bridge_defs.sv"
`endif

package egr_pkt_fifo_pkg;

  localparam int unsigned PFW_W    = `PFW_SZ;
  localparam int unsigned TX_DEPTH = `TX_FIFO_DEPTH;
  localparam int unsigned TX_USG_W = `TX_USG_SZ;

  typedef enum logic [1:0] {
    PCC_IDLE   = `PCC_IDLE,
    PCC_DATA   = `PCC_DATA,
    PCC_COMMIT = `PCC_COMMIT,
    PCC_ABORT  = `PCC_ABORT
  } pcc_e;

  // Abort dominates everything; commit only counts on an accepted write.
  function automatic pcc_e pcc_decode(input logic wr_fire,
                                      input logic commit,
                                      input logic abort);
    if (abort)    return PCC_ABORT;
    if (!wr_fire) return PCC_IDLE;
    if (commit)   return PCC_COMMIT;
    return PCC_DATA;
  endfunction

endpackage

// File: rtl/bridge_defs.sv
// Shared bridge definitions: datapath width, egress FIFO sizing and packet control codes.
`ifndef EGR_BRIDGE_DEFS_SV
`define EGR_BRIDGE_DEFS_SV

`define PFW_SZ        64
`define TX_FIFO_DEPTH 16
`define TX_USG_SZ     5

// Packet control codes: what the producer side does to the FIFO in a cycle.
`define PCC_IDLE   2'b00
`define PCC_DATA   2'b01
`define PCC_COMMIT 2'b10
`define PCC_ABORT  2'b11

`endif

// File: rtl/egr_pfifo_mem.sv
// Egress FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module egr_pfifo_mem #(
  parameter int unsigned depth = 16,
  parameter int unsigned width = 64
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(depth)-1:0] wr_addr_i,
  input  logic [width-1:0]         wr_data_i,
  input  logic [$clog2(depth)-1:0] rd_addr_i,
  output logic [width-1:0]         rd_data_o
);

  logic [width-1:0] mem_q [depth];

  // Word write; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read is a plain mux off the read pointer.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/egr_pkt_fifo.sv
// Egress packet FIFO: words become visible to the consumer only once their packet
// is committed; an abort rolls the speculative write pointer back to the last commit.
module egr_pkt_fifo
  import egr_pkt_fifo_pkg::*;
#(
  parameter int unsigned depth = `TX_FIFO_DEPTH,
  parameter int unsigned width = `PFW_SZ
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_srdy,
  output logic                c_drdy,
  input  logic [width-1:0]    c_data,
  input  logic                c_commit,
  input  logic                c_abort,
  output logic                p_srdy,
  input  logic                p_drdy,
  output logic [width-1:0]    p_data,
  output logic [TX_USG_W-1:0] tx_usage
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] com_ptr_q, com_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0] occ;
  logic          wr_fire;
  logic          rd_fire;
  logic          mem_we;
  pcc_e          pcc;

  // Status derived purely from pointer flops.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign c_drdy   = (occ != PW'(depth));
  assign p_srdy   = (com_ptr_q != rd_ptr_q);
  assign tx_usage = TX_USG_W'(occ);

  // Handshakes and producer-side control classification.
  assign wr_fire = c_srdy & c_drdy;
  assign rd_fire = p_srdy & p_drdy;
  assign pcc     = pcc_decode(wr_fire, c_commit, c_abort);
  assign mem_we  = (pcc == PCC_DATA) || (pcc == PCC_COMMIT);

  // Next-state pointers; read side is independent of the producer side.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    com_ptr_d = com_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    unique case (pcc)
      PCC_IDLE: ;
      PCC_DATA: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      PCC_COMMIT: begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        com_ptr_d = wr_ptr_q + PW'(1);
      end
      PCC_ABORT: begin
        wr_ptr_d = com_ptr_q;
      end
    endcase
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers with synchronous reset; reset drops all queued data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      com_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      com_ptr_q <= com_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  egr_pfifo_mem #(
    .depth (depth),
    .width (width)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (c_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (p_data)
  );

endmodule

// File: doc/egr_pkt_fifo.md
EGR_PKT_FIFO -- requirements
Module: egr_pkt_fifo

Interface
REQ-001 SHALL have parameter depth, default `TX_FIFO_DEPTH, number of storage words; power of two, minimum 4.
REQ-002 SHALL have parameter width, default `PFW_SZ, data word width in bits.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high on clock clk.
REQ-005 SHALL have port c_srdy, input, 1, producer word valid.
REQ-006 SHALL have port c_drdy, output, 1, FIFO can accept a word.
REQ-007 SHALL have port c_data, input, width, producer word.
REQ-008 SHALL have port c_commit, input, 1, accepted word closes the packet; packet becomes readable.
REQ-009 SHALL have port c_abort, input, 1, discard all uncommitted words.
REQ-010 SHALL have port p_srdy, output, 1, committed word available.
REQ-011 SHALL have port p_drdy, input, 1, consumer ready.
REQ-012 SHALL have port p_data, output, width, word at read pointer.
REQ-013 SHALL have port tx_usage, output, `TX_USG_SZ, total occupancy (committed plus uncommitted).

Function
REQ-014 SHALL keep three pointers of log2(depth)+1 bits (MSB = wrap bit): wr_ptr (speculative), com_ptr (committed), rd_ptr.
REQ-015 SHALL derive occupancy as wr_ptr - rd_ptr, modulo 2^(log2(depth)+1), and drive it on tx_usage combinationally from flops.
REQ-016 SHALL drive c_drdy = (occupancy != depth); full is decided by speculative occupancy.
REQ-017 SHALL treat a write as c_srdy & c_drdy: store c_data at wr_ptr low bits and increment wr_ptr at that edge.
REQ-018 SHALL sample c_commit only on a write cycle; then com_ptr <= wr_ptr + 1, which includes the word written that cycle.
REQ-019 SHALL ignore c_commit when there is no write.
REQ-020 SHALL sample c_abort every cycle regardless of c_srdy/c_drdy; on abort, wr_ptr <= com_ptr and any word offered in that cycle is discarded.
REQ-021 SHALL give abort priority when c_abort and c_commit are both asserted; com_ptr is then unchanged.
REQ-022 SHALL drive p_srdy = (com_ptr != rd_ptr); uncommitted words are never visible.
REQ-023 SHALL drive p_data combinationally from the storage word at rd_ptr low bits.
REQ-024 SHALL increment rd_ptr at the edge where p_srdy & p_drdy.
REQ-025 SHALL have one-cycle latency: a word committed at edge N gives p_srdy=1 in the cycle after N.
REQ-026 SHALL apply a read and a write or commit/abort in the same cycle independently; tx_usage reflects both next cycle.
REQ-027 SHALL wrap all pointers naturally at 2^(log2(depth)+1), with no special case for wrap.
REQ-028 SHALL never overrun unread data: abort restores only wr_ptr and never moves rd_ptr or com_ptr.

Reset
REQ-029 SHALL, while reset is asserted, clear wr_ptr, com_ptr and rd_ptr to 0, giving p_srdy=0, c_drdy=1 and tx_usage=0 the cycle after.
REQ-030 SHALL discard a packet in progress, and all committed data, on reset mid-packet.
REQ-031 SHALL not reset the storage array.

Structure
REQ-032 SHALL place `PFW_SZ, `TX_FIFO_DEPTH, `TX_USG_SZ and the PCC codes in the shared bridge definitions include, not local to this block.
REQ-033 SHALL place the storage array in sub-module egr_pfifo_mem (one write port, one asynchronous read port, parameters depth and width).
REQ-034 SHALL keep pointer and handshake logic in egr_pkt_fifo.

Verification (depth=16)
REQ-035 SHALL cover: 4 words 0xA0..0xA3, commit on 4th, p_drdy=1 -> p_srdy rises next cycle, words out in order, tx_usage 4->0.
REQ-036 SHALL cover: 3 words then c_abort with c_srdy=0 -> tx_usage returns to 0 next cycle, p_srdy never asserted.
REQ-037 SHALL cover: 16 words, no commit -> c_drdy=0 at tx_usage=16; abort -> c_drdy=1 and tx_usage=0 next cycle.
REQ-038 SHALL cover: packet A (5 words) committed, packet B (3 words) aborted, p_drdy=0 during -> A's 5 words read, then p_srdy=0.
REQ-039 SHALL cover: c_commit and c_abort together on a write -> abort wins, tx_usage equals prior committed count.
REQ-040 SHALL cover: 10 packets of 7 words with continuous read (pointer wrap), then reset mid-packet -> data intact through wrap; after reset p_srdy=0 and tx_usage=0.
